// File: rtl/imm_pkg.sv
// Shared opcodes, format codes and the pure immediate decoder for imm_gen_pipe.
package imm_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_OPIMM    = 7'b0010011;
    localparam logic [6:0] OP_FENCE    = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_OPIMM32  = 7'b0011011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    typedef struct packed {
        logic [63:0] imm;
        imm_fmt_e    fmt;
        logic        illegal;
    } dec_t;

    // Always decodes at 64 bits; a 32-bit datapath keeps the low half,
    // which is identical because every immediate is sign-extended from bit 31.
    // Every legal opcode ends in 2'b11, so the default arm also covers a bad instr[1:0].
    function automatic dec_t decode_imm(input logic [31:0] instr, input logic is64);
        dec_t d;
        d.imm     = '0;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b0;
        case (instr[6:0])
            OP_LUI, OP_AUIPC: begin
                d.fmt = FMT_U;
                d.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            end
            OP_JAL: begin
                d.fmt = FMT_J;
                d.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE: begin
                d.fmt = FMT_I;
                d.imm = {{52{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                d.fmt = FMT_S;
                d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                d.fmt = FMT_B;
                d.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_OP: begin
                d.fmt = FMT_NONE;
            end
            OP_SYSTEM: begin
                if (instr[14]) begin
                    d.fmt = FMT_Z;
                    d.imm = {59'b0, instr[19:15]};
                end else begin
                    d.fmt = FMT_I;
                    d.imm = {{52{instr[31]}}, instr[31:20]};
                end
            end
            OP_OPIMM32: begin
                if (is64) begin
                    d.fmt = FMT_I;
                    d.imm = {{52{instr[31]}}, instr[31:20]};
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_skid_buf.sv
// Two-entry elastic buffer: main drives the outputs, skid absorbs one entry
// when downstream stalls. Order is preserved; ready comes straight from a flop.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_accept
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a valid source holds its data until that edge.
    logic         r_main_valid;
    logic         r_skid_valid;
    logic         r_ready;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;

    logic         w_accept;
    logic         w_drain;
    logic         w_main_valid_nxt;
    logic         w_skid_valid_nxt;
    logic [W-1:0] w_main_nxt;
    logic [W-1:0] w_skid_nxt;

    assign w_accept = i_valid & r_ready & ~flush;
    assign w_drain  = r_main_valid & i_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (r_main_valid && !w_drain) begin
            if (w_accept) begin
                w_skid_valid_nxt = 1'b1;
                w_skid_nxt       = i_data;
            end
        end else if (r_skid_valid) begin
            w_main_valid_nxt = 1'b1;
            w_main_nxt       = r_skid;
            w_skid_valid_nxt = 1'b0;
        end else begin
            w_main_valid_nxt = w_accept;
            if (w_accept) begin
                w_main_nxt = i_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_main       <= '0;
            r_skid       <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= ~w_skid_valid_nxt;
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_main_valid;
    assign o_data   = r_main;
    assign o_accept = w_accept;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decodes on accept, buffers through a
// skid buffer and counts accepted illegal instructions (saturating).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] illegal_cnt
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } imm_entry_t;

    localparam int ENTRY_W = $bits(imm_entry_t);

    dec_t             w_dec;
    imm_entry_t       w_in_entry;
    imm_entry_t       w_out_entry;
    logic             w_accept;
    logic [CNT_W-1:0] r_illegal_cnt;

    always_comb begin
        w_dec              = decode_imm(in_instr, XLEN == 64);
        w_in_entry.imm     = XLEN'(w_dec.imm);
        w_in_entry.fmt     = w_dec.fmt;
        w_in_entry.illegal = w_dec.illegal;
        w_in_entry.pc      = in_pc;
    end

    skid_buf #(.W(ENTRY_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .i_valid  (in_valid),
        .o_ready  (in_ready),
        .i_data   (w_in_entry),
        .o_valid  (out_valid),
        .i_ready  (out_ready),
        .o_data   (w_out_entry),
        .o_accept (w_accept)
    );

    // Counts at accept time, so a later flush does not undo the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_accept && w_dec.illegal && !(&r_illegal_cnt)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign out_imm     = w_out_entry.imm;
    assign out_fmt     = w_out_entry.fmt;
    assign out_illegal = w_out_entry.illegal;
    assign out_pc      = w_out_entry.pc;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32, XLEN=64 and CNT_W=2 instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] pc64;
  logic        out_ready;

  logic        o32_in_ready, o32_valid, o32_ill;
  logic [31:0] o32_imm, o32_pc;
  logic [2:0]  o32_fmt;
  logic [15:0] o32_cnt;

  logic        o64_in_ready, o64_valid, o64_ill;
  logic [63:0] o64_imm, o64_pc;
  logic [2:0]  o64_fmt;
  logic [15:0] o64_cnt;

  logic        os_in_ready, os_valid, os_ill;
  logic [31:0] os_imm, os_pc;
  logic [2:0]  os_fmt;
  logic [1:0]  os_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt32 = 0;
  int m_cnt64 = 0;
  int m_cnts = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o32_in_ready),
    .in_instr(in_instr), .in_pc(pc64[31:0]), .out_valid(o32_valid), .out_ready(out_ready),
    .out_imm(o32_imm), .out_fmt(o32_fmt), .out_illegal(o32_ill), .out_pc(o32_pc),
    .illegal_cnt(o32_cnt));

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o64_in_ready),
    .in_instr(in_instr), .in_pc(pc64), .out_valid(o64_valid), .out_ready(out_ready),
    .out_imm(o64_imm), .out_fmt(o64_fmt), .out_illegal(o64_ill), .out_pc(o64_pc),
    .illegal_cnt(o64_cnt));

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(os_in_ready),
    .in_instr(in_instr), .in_pc(pc64[31:0]), .out_valid(os_valid), .out_ready(out_ready),
    .out_imm(os_imm), .out_fmt(os_fmt), .out_illegal(os_ill), .out_pc(os_pc),
    .illegal_cnt(os_cnt));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32;
    logic [2:0]  fmt64;
    logic        ill32;
    logic        ill64;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_accept(input logic il32, input logic il64);
    m_cnt32 += int'(il32);
    m_cnt64 += int'(il64);
    if (il32 && m_cnts < 3) m_cnts++;
  endtask

  task automatic check_cnt(input string n);
    chk({n, " cnt32"}, 64'(o32_cnt), 64'(m_cnt32));
    chk({n, " cnt64"}, 64'(o64_cnt), 64'(m_cnt64));
    chk({n, " cnt_sat"}, 64'(os_cnt), 64'(m_cnts));
  endtask

  task automatic check_ready(input string n, input logic exp);
    chk({n, " rdy32"}, 64'(o32_in_ready), 64'(exp));
    chk({n, " rdy64"}, 64'(o64_in_ready), 64'(exp));
    chk({n, " rdy_sat"}, 64'(os_in_ready), 64'(exp));
  endtask

  task automatic check_valid(input string n, input logic exp);
    chk({n, " v32"}, 64'(o32_valid), 64'(exp));
    chk({n, " v64"}, 64'(o64_valid), 64'(exp));
    chk({n, " v_sat"}, 64'(os_valid), 64'(exp));
  endtask

  task automatic check_out(input string n, input vec_t v, input logic [63:0] pc);
    check_valid(n, 1'b1);
    chk({n, " imm32"}, 64'(o32_imm), 64'(v.imm32));
    chk({n, " imm64"}, o64_imm, v.imm64);
    chk({n, " imm_sat"}, 64'(os_imm), 64'(v.imm32));
    chk({n, " fmt32"}, 64'(o32_fmt), 64'(v.fmt32));
    chk({n, " fmt64"}, 64'(o64_fmt), 64'(v.fmt64));
    chk({n, " fmt_sat"}, 64'(os_fmt), 64'(v.fmt32));
    chk({n, " ill32"}, 64'(o32_ill), 64'(v.ill32));
    chk({n, " ill64"}, 64'(o64_ill), 64'(v.ill64));
    chk({n, " ill_sat"}, 64'(os_ill), 64'(v.ill32));
    chk({n, " pc32"}, 64'(o32_pc), {32'b0, pc[31:0]});
    chk({n, " pc64"}, o64_pc, pc);
    chk({n, " pc_sat"}, 64'(os_pc), {32'b0, pc[31:0]});
  endtask

  task automatic check_zero(input string n);
    check_valid(n, 1'b0);
    chk({n, " imm32"}, 64'(o32_imm), 64'd0);
    chk({n, " imm64"}, o64_imm, 64'd0);
    chk({n, " fmt32"}, 64'(o32_fmt), 64'd0);
    chk({n, " fmt64"}, 64'(o64_fmt), 64'd0);
    chk({n, " ill32"}, 64'(o32_ill), 64'd0);
    chk({n, " ill64"}, 64'(o64_ill), 64'd0);
    chk({n, " pc32"}, 64'(o32_pc), 64'd0);
    chk({n, " pc64"}, o64_pc, 64'd0);
    chk({n, " imm_sat"}, 64'(os_imm), 64'd0);
    chk({n, " pc_sat"}, 64'(os_pc), 64'd0);
    chk({n, " fmt_sat"}, 64'(os_fmt), 64'd0);
    chk({n, " ill_sat"}, 64'(os_ill), 64'd0);
    check_cnt(n);
  endtask

  logic [31:0] exp_q[$];

  initial begin
    vecs[0]  = '{32'hFEDCB037, 32'hFEDCB000, 64'hFFFFFFFF_FEDCB000, 3'd4, 3'd4, 1'b0, 1'b0};
    vecs[1]  = '{32'hFE100EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 3'd3, 1'b0, 1'b0};
    vecs[2]  = '{32'hFF9FF0EF, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd5, 3'd5, 1'b0, 1'b0};
    vecs[3]  = '{32'hFE102E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0};
    vecs[4]  = '{32'h80000093, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000001B, 32'h00000000, 64'h0, 3'd0, 3'd1, 1'b1, 1'b0};
    vecs[6]  = '{32'h0002D073, 32'h00000005, 64'h5, 3'd6, 3'd6, 1'b0, 1'b0};
    vecs[7]  = '{32'h12345678, 32'h00000000, 64'h0, 3'd0, 3'd0, 1'b1, 1'b1};
    vecs[8]  = '{32'h00000033, 32'h00000000, 64'h0, 3'd0, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{32'h00A00513, 32'h0000000A, 64'hA, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[10] = '{32'hC0002073, 32'hFFFFFC00, 64'hFFFFFFFF_FFFFFC00, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[11] = '{32'h00000000, 32'h00000000, 64'h0, 3'd0, 3'd0, 1'b1, 1'b1};
    vecs[12] = '{32'h00208463, 32'h00000008, 64'h8, 3'd3, 3'd3, 1'b0, 1'b0};
    vecs[13] = '{32'h12345037, 32'h12345000, 64'h00000000_12345000, 3'd4, 3'd4, 1'b0, 1'b0};

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    pc64 = 64'h0;
    out_ready = 1'b1;
    #2;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_ready("post_reset", 1'b1);

    // Back-to-back table sweep, out_ready held high.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      pc64 = {32'hABCD0000, 32'h1000 + 32'(4 * i)};
      @(posedge clk);
      model_accept(vecs[i].ill32, vecs[i].ill64);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i], pc64);
      check_cnt($sformatf("vec%0d", i));
      check_ready($sformatf("vec%0d", i), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_valid("drained", 1'b0);

    // Backpressure: three offers with out_ready low, then release.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00A00513;
    pc64 = 64'h100;
    @(posedge clk);
    exp_q.push_back(32'h100);
    #1;
    check_ready("bp_first", 1'b1);
    chk("bp_first pc", 64'(o32_pc), 64'h100);
    @(negedge clk);
    pc64 = 64'h104;
    @(posedge clk);
    exp_q.push_back(32'h104);
    #1;
    check_ready("bp_second", 1'b0);
    chk("bp_second pc", 64'(o32_pc), 64'h100);
    @(negedge clk);
    pc64 = 64'h108;
    @(posedge clk);
    #1;
    check_ready("bp_stall", 1'b0);
    chk("bp_stall pc", 64'(o32_pc), 64'h100);
    chk("bp_stall pc64", o64_pc, 64'h100);
    begin
      logic offering;
      int   drains;
      int   first_c;
      int   last_c;
      offering = 1'b1;
      drains = 0;
      first_c = -1;
      last_c = -1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = offering;
        #1;
        if (o32_valid) begin
          if (exp_q.size() == 0) begin
            chk("bp_dup", 64'(o32_pc), 64'hDEAD);
          end else begin
            chk($sformatf("bp_order%0d", drains), 64'(o32_pc), 64'(exp_q.pop_front()));
          end
          if (first_c < 0) first_c = c;
          last_c = c;
          drains++;
        end
        if (in_valid && o32_in_ready) begin
          exp_q.push_back(pc64[31:0]);
          offering = 1'b0;
        end
        @(posedge clk);
      end
      chk("bp_drains", 64'(drains), 64'd3);
      chk("bp_consecutive", 64'(last_c - first_c), 64'd2);
      chk("bp_leftover", 64'(exp_q.size()), 64'd0);
    end

    // Flush with both entries full; the first entry is illegal and stays counted.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h12345678;
    pc64 = 64'h200;
    @(posedge clk);
    model_accept(1'b1, 1'b1);
    @(negedge clk);
    in_instr = 32'h00A00513;
    pc64 = 64'h204;
    @(posedge clk);
    #1;
    check_ready("flush_pre", 1'b0);
    check_cnt("flush_pre");
    @(negedge clk);
    flush = 1'b1;
    pc64 = 64'h208;
    @(posedge clk);
    #1;
    check_valid("flush", 1'b0);
    check_ready("flush", 1'b1);
    check_cnt("flush");
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_valid("flush_after", 1'b0);

    // One more illegal: five accepted in total, CNT_W=2 instance pinned at 3.
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h0000007F;
    pc64 = 64'h300;
    @(posedge clk);
    model_accept(1'b1, 1'b1);
    #1;
    chk("sat ill32", 64'(o32_ill), 64'd1);
    chk("sat total32", 64'(o32_cnt), 64'd5);
    chk("sat cnt2", 64'(os_cnt), 64'd3);
    check_cnt("sat");

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge clk);
    out_ready = 1'b0;
    in_instr = 32'hFEDCB037;
    pc64 = 64'h304;
    @(posedge clk);
    #1;
    check_valid("pre_rst", 1'b1);
    #2;
    rst = 1'b1;
    m_cnt32 = 0;
    m_cnt64 = 0;
    m_cnts = 0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_ready("rst_release", 1'b1);
    check_valid("rst_release", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
